// File: rtl/sine_nco_multi.sv
`default_nettype none
// ============================================================================
// Module      : sine_nco_multi
// Description : Time-multiplexed N-channel NCO sharing one quarter-wave sine
//               table; valid/ready output tagged with channel number.
//               Optional linear interpolation: define SINE_INTERP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sine_nco_multi #(
    parameter  int NUM_CH  = 4,
    parameter  int PHASE_W = 24,
    parameter  int LUT_AW  = 7,
    parameter  int OUT_W   = 16,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_sel,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [PHASE_W-1:0] cfg_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CH_W-1:0]    out_ch,
    output logic [OUT_W-1:0]   out_data
);
    localparam int              c_n       = 2 ** LUT_AW;
    localparam int              c_iw      = LUT_AW + 2;
    localparam logic [CH_W-1:0] c_last_ch = CH_W'(NUM_CH - 1);
    localparam logic [1:0]      c_sel_fcw = 2'd0;
    localparam logic [1:0]      c_sel_off = 2'd1;
    localparam logic [1:0]      c_sel_clr = 2'd2;

    function automatic logic [OUT_W-1:0] sine_entry(input int k);
        real amp;
        real v;
        amp = (2.0 ** (OUT_W - 1)) - 1.0;
        v   = amp * $sin(3.14159265358979323846 * real'(k) / real'(2 * c_n));
        return OUT_W'($rtoi(v + 0.5));
    endfunction

    // Odd quadrants read the table mirrored: T[N - x].
    function automatic logic [LUT_AW:0] fold_idx(input logic [c_iw-1:0] i);
        logic [LUT_AW:0] x;
        x = {1'b0, i[LUT_AW-1:0]};
        return i[LUT_AW] ? ((LUT_AW + 1)'(c_n) - x) : x;
    endfunction

    logic [OUT_W-1:0] w_lut [c_n + 1];
    for (genvar k = 0; k <= c_n; k++) begin : g_lut
        localparam logic [OUT_W-1:0] c_val = sine_entry(k);
        assign w_lut[k] = c_val;
    end

    logic [PHASE_W-1:0] r_acc [NUM_CH];
    logic [PHASE_W-1:0] r_fcw [NUM_CH];
    logic [PHASE_W-1:0] r_off [NUM_CH];
    logic [CH_W-1:0]    r_ch_ptr;
    logic               w_stall;
    logic               w_adv;
    logic               w_issue;
    logic [PHASE_W-1:0] w_phase;

    assign w_stall = out_valid & ~out_ready;
    assign w_adv   = ~w_stall;
    assign w_issue = enable & w_adv;
    assign w_phase = r_acc[r_ch_ptr] + r_off[r_ch_ptr];

    // Clear is applied after the increment so it wins on a same-cycle issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ch_ptr <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_acc[c] <= '0;
                r_fcw[c] <= '0;
                r_off[c] <= '0;
            end
        end else begin
            if (w_issue)
                r_ch_ptr <= (r_ch_ptr == c_last_ch) ? '0 : r_ch_ptr + CH_W'(1);
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_issue && r_ch_ptr == CH_W'(c))
                    r_acc[c] <= r_acc[c] + r_fcw[c];
                if (cfg_we && cfg_ch == CH_W'(c)) begin
                    case (cfg_sel)
                        c_sel_fcw: r_fcw[c] <= cfg_data;
                        c_sel_off: r_off[c] <= cfg_data;
                        c_sel_clr: r_acc[c] <= '0;
                        default:   ;
                    endcase
                end
            end
        end
    end

    logic                    r_s0_valid;
    logic [CH_W-1:0]         r_s0_ch;
    logic [PHASE_W-1:0]      r_s0_phase;
    logic                    r_s1_valid;
    logic [CH_W-1:0]         r_s1_ch;
    logic [OUT_W-1:0]        r_s1_mag0;
    logic                    r_s1_neg0;
    logic                    r_s2_valid;
    logic [CH_W-1:0]         r_s2_ch;
    logic signed [OUT_W-1:0] r_s2_y0;
    logic [c_iw-1:0]         w_i0;
    logic [LUT_AW:0]         w_idx0;
    logic                    w_last_valid;
    logic [CH_W-1:0]         w_last_ch;
    logic [OUT_W-1:0]        w_last_data;
    logic                    w_unused_phase;

    assign w_i0           = r_s0_phase[PHASE_W-1 -: c_iw];
    assign w_idx0         = fold_idx(w_i0);
    assign w_unused_phase = ^r_s0_phase;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s0_valid <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_data   <= '0;
        end else if (w_adv) begin
            r_s0_valid <= enable;
            r_s0_ch    <= r_ch_ptr;
            r_s0_phase <= w_phase;
            r_s1_valid <= r_s0_valid;
            r_s1_ch    <= r_s0_ch;
            r_s1_mag0  <= w_lut[w_idx0];
            r_s1_neg0  <= w_i0[c_iw-1];
            r_s2_valid <= r_s1_valid;
            r_s2_ch    <= r_s1_ch;
            r_s2_y0    <= r_s1_neg0 ? -r_s1_mag0 : r_s1_mag0;
            out_valid  <= w_last_valid;
            out_ch     <= w_last_ch;
            out_data   <= w_last_data;
        end
    end

`ifdef SINE_INTERP_EN
    localparam int c_f  = ((PHASE_W - c_iw) < 8) ? (PHASE_W - c_iw) : 8;
    localparam int c_pw = OUT_W + c_f + 1;

    logic [c_iw-1:0]         w_i1;
    logic [LUT_AW:0]         w_idx1;
    logic [OUT_W-1:0]        r_s1_mag1;
    logic                    r_s1_neg1;
    logic [c_f-1:0]          r_s1_frac;
    logic signed [OUT_W-1:0] r_s2_y1;
    logic [c_f-1:0]          r_s2_frac;
    logic                    r_s3_valid;
    logic [CH_W-1:0]         r_s3_ch;
    logic [OUT_W-1:0]        r_s3_data;
    logic signed [c_pw-1:0]  w_y0x;
    logic signed [c_pw-1:0]  w_diff;
    logic signed [c_pw-1:0]  w_prod;
    logic signed [c_pw-1:0]  w_sum;
    logic                    w_unused_sum;

    assign w_i1   = w_i0 + c_iw'(1);
    assign w_idx1 = fold_idx(w_i1);
    assign w_y0x  = c_pw'(r_s2_y0);
    assign w_diff = c_pw'(r_s2_y1) - w_y0x;
    assign w_prod = w_diff * $signed({{(c_pw - c_f){1'b0}}, r_s2_frac});
    assign w_sum  = w_y0x + (w_prod >>> c_f);
    assign w_unused_sum = ^w_sum[c_pw-1:OUT_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s3_valid <= 1'b0;
        end else if (w_adv) begin
            r_s1_mag1  <= w_lut[w_idx1];
            r_s1_neg1  <= w_i1[c_iw-1];
            r_s1_frac  <= r_s0_phase[PHASE_W-c_iw-1 -: c_f];
            r_s2_y1    <= r_s1_neg1 ? -r_s1_mag1 : r_s1_mag1;
            r_s2_frac  <= r_s1_frac;
            r_s3_valid <= r_s2_valid;
            r_s3_ch    <= r_s2_ch;
            r_s3_data  <= w_sum[OUT_W-1:0];
        end
    end

    assign w_last_valid = r_s3_valid;
    assign w_last_ch    = r_s3_ch;
    assign w_last_data  = r_s3_data;
`else
    assign w_last_valid = r_s2_valid;
    assign w_last_ch    = r_s2_ch;
    assign w_last_data  = r_s2_y0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sine_nco_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_sine_nco_multi
// Description : Directed self-checking bench for sine_nco_multi (3 channels so
//               that cfg_ch=3 is a representable out-of-range channel).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sine_nco_multi;
    localparam int NUM_CH  = 3;
    localparam int PHASE_W = 16;
    localparam int LUT_AW  = 7;
    localparam int OUT_W   = 16;
    localparam int CH_W    = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enable = 1'b0;
    logic               cfg_we = 1'b0;
    logic [1:0]         cfg_sel = 2'd0;
    logic [CH_W-1:0]    cfg_ch = '0;
    logic [PHASE_W-1:0] cfg_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [CH_W-1:0]    out_ch;
    logic [OUT_W-1:0]   out_data;

    int vectors     = 0;
    int miscompares = 0;

    sine_nco_multi #(
        .NUM_CH  (NUM_CH),
        .PHASE_W (PHASE_W),
        .LUT_AW  (LUT_AW),
        .OUT_W   (OUT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_ch    (cfg_ch),
        .cfg_data  (cfg_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_sample(input string tag, input int ch, input logic [15:0] data);
        tick();
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".ch"},    32'(out_ch),    32'(ch));
        check({tag, ".data"},  32'(out_data),  32'(data));
    endtask

    task automatic expect_idle(input string tag);
        tick();
        check({tag, ".valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [CH_W-1:0] ch, input logic [15:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_ch   = ch;
        cfg_data = data;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic restart();
        rst_n  = 1'b0;
        enable = 1'b0;
        tick();
        tick();
        rst_n  = 1'b1;
    endtask

    // Enables issue and checks the three empty cycles before the first sample.
    task automatic start(input string tag);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) expect_idle($sformatf("%s.lat%0d", tag, i));
    endtask

    // Stream for the quadrant/offset setup: ch0 steps 0x4000, ch1 at +90deg, ch2 at +270deg.
    function automatic logic [15:0] quad_data(input int n);
        logic [15:0] pat [4];
        pat = '{16'h0000, 16'h7FFF, 16'h0000, 16'h8001};
        case (n % 3)
            0:       return pat[(n / 3) % 4];
            1:       return 16'h7FFF;
            default: return 16'h8001;
        endcase
    endfunction

    initial begin
        // Reset held with enable high: outputs stay zero.
        enable = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.ch",    32'(out_ch),    32'd0);
        check("rst.data",  32'(out_data),  32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) expect_idle($sformatf("first.lat%0d", i));
        for (int n = 0; n < 4; n++) expect_sample($sformatf("first%0d", n), n % 3, 16'h0000);

        // Quadrants, offsets, ignored out-of-range writes, backpressure.
        restart();
        cfg(2'd0, 2'd0, 16'h4000);
        cfg(2'd1, 2'd1, 16'h4000);
        cfg(2'd1, 2'd2, 16'hC000);
        cfg(2'd0, 2'd3, 16'h2000);
        cfg(2'd1, 2'd3, 16'h4000);
        cfg(2'd2, 2'd3, 16'h0000);
        start("quad");
        for (int n = 0; n < 4; n++) expect_sample($sformatf("quad%0d", n), n % 3, quad_data(n));
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) expect_sample($sformatf("stall%0d", i), 0, 16'h7FFF);
        out_ready = 1'b1;
        for (int n = 4; n < 18; n++) expect_sample($sformatf("quad%0d", n), n % 3, quad_data(n));

        // Clear coinciding with the ch0 issue whose phase is 0x4000.
        restart();
        cfg(2'd0, 2'd0, 16'h2000);
        start("clr");
        expect_sample("clr0", 0, 16'h0000);
        expect_sample("clr1", 1, 16'h0000);
        expect_sample("clr2", 2, 16'h0000);
        cfg_we = 1'b1; cfg_sel = 2'd2; cfg_ch = 2'd0; cfg_data = 16'h0000;
        expect_sample("clr3", 0, 16'h5A82);
        cfg_we = 1'b0;
        expect_sample("clr4", 1, 16'h0000);
        expect_sample("clr5", 2, 16'h0000);
        expect_sample("clr6", 0, 16'h7FFF);
        expect_sample("clr7", 1, 16'h0000);
        expect_sample("clr8", 2, 16'h0000);
        expect_sample("clr9", 0, 16'h0000);
        expect_sample("clr10", 1, 16'h0000);
        expect_sample("clr11", 2, 16'h0000);
        expect_sample("clr12", 0, 16'h5A82);

        // Phase wrap 0 -> 0xFFFF lands in q=3, x=127: -T[1].
        restart();
        cfg(2'd0, 2'd0, 16'hFFFF);
        start("wrap");
        for (int n = 0; n < 6; n++)
            expect_sample($sformatf("wrap%0d", n), n % 3,
                          (n % 3 == 0 && n > 0) ? 16'hFE6E : 16'h0000);
        // Disable: the three in-flight samples still drain.
        enable = 1'b0;
        expect_sample("drain0", 0, 16'hFE6E);
        expect_sample("drain1", 1, 16'h0000);
        expect_sample("drain2", 2, 16'h0000);
        expect_idle("drain3");
        expect_idle("drain4");

        // Reset mid-stream discards in-flight samples.
        enable = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        check("midrst.valid", 32'(out_valid), 32'd0);
        check("midrst.data",  32'(out_data),  32'd0);
        rst_n  = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) expect_idle($sformatf("midrst.idle%0d", i));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
